// File: rtl/bch_syndrome_gen.sv
// BCH syndrome generator: Horner accumulation of S1..S2t over GF(2^m), 8 received bits per beat.
// Optional BCH_SYN_EVEN_SQR_EN: accumulate odd lanes only and derive even lanes by squaring.
module bch_syndrome_gen #(
  parameter int unsigned MMax  = 10,
  parameter int unsigned TMax  = 4,
  parameter int unsigned BeatW = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [1:0]               code_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [BeatW-1:0]         in_bits_i,
  output logic                     syn_valid_o,
  input  logic                     syn_ready_i,
  output logic [2*TMax*MMax-1:0]   syn_o,
  output logic                     syn_zero_o,
  output logic                     busy_o
);

  localparam int unsigned NumLanes = 2 * TMax;
  localparam int unsigned T2Lanes  = 4;
  localparam int unsigned CntW     = 7;

`ifdef BCH_SYN_EVEN_SQR_EN
  localparam bit SqrEn = 1'b1;
`else
  localparam bit SqrEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StAcc, StSqr, StDone} state_e;

  state_e                        state_q, state_d;
  logic [1:0]                    code_q, code_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [NumLanes-1:0][MMax-1:0] acc_q, acc_d, acc_beat;
  logic [MMax-1:0]               sq2, sq4;
  logic                          start_ok, accept, last_beat;

  // Multiply by alpha and reduce with the field polynomial of the selected code.
  function automatic logic [MMax-1:0] xtime(input logic [MMax-1:0] a, input logic [1:0] c);
    logic [MMax-1:0] r;
    case (c)
      2'd1:    r = MMax'({a[4:0], 1'b0} ^ (a[5] ? 6'h03 : 6'h00));
      2'd2:    r = MMax'({a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00));
      2'd3:    r = MMax'({a[8:0], 1'b0} ^ (a[9] ? 10'h009 : 10'h000));
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [MMax-1:0] mul_pow(input logic [MMax-1:0] a, input int unsigned p,
                                              input logic [1:0] c);
    logic [MMax-1:0] r;
    r = a;
    for (int unsigned k = 0; k < NumLanes; k++) begin
      if (k < p) r = xtime(r, c);
    end
    return r;
  endfunction

  function automatic logic [MMax-1:0] gf_sq(input logic [MMax-1:0] a, input logic [1:0] c);
    logic [MMax-1:0] r;
    r = '0;
    for (int i = MMax - 1; i >= 0; i--) begin
      r = xtime(r, c);
      if (a[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [CntW-1:0] last_idx(input logic [1:0] c);
    logic [CntW-1:0] r;
    case (c)
      2'd1:    r = CntW'(7);
      2'd2:    r = CntW'(31);
      default: r = CntW'(127);
    endcase
    return r;
  endfunction

  assign start_ok  = (state_q == StIdle) && start_i && (code_i != 2'd0);
  assign accept    = (state_q == StAcc) && in_valid_i;
  assign last_beat = (cnt_q == last_idx(code_q));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      code_q  <= 2'd0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_ok) state_d = StAcc;
      StAcc:  if (accept && last_beat) state_d = SqrEn ? StSqr : StDone;
      StSqr:  state_d = StDone;
      StDone: if (syn_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready_o  = (state_q == StAcc);
    syn_valid_o = (state_q == StDone);
    busy_o      = (state_q != StIdle);
  end

  // One beat of Horner steps; the first beat's MSB is padding and is skipped.
  always_comb begin
    acc_beat = acc_q;
    for (int unsigned l = 0; l < NumLanes; l++) begin
      for (int b = BeatW - 1; b >= 0; b--) begin
        if (!((b == BeatW - 1) && (cnt_q == '0))) begin
          acc_beat[l] = mul_pow(acc_beat[l], l + 1, code_q) ^ MMax'(in_bits_i[b]);
        end
      end
    end
  end

  // S8 = S4^2 chains through S4 = S2^2 within the single squaring cycle.
  assign sq2 = gf_sq(acc_q[0], code_q);
  assign sq4 = gf_sq(sq2, code_q);

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    code_d = code_q;
    if (start_ok) begin
      acc_d  = '0;
      cnt_d  = '0;
      code_d = code_i;
    end else if (accept) begin
      cnt_d = cnt_q + CntW'(1);
      for (int unsigned l = 0; l < NumLanes; l++) begin
        if (!SqrEn || (l % 2 == 0)) acc_d[l] = acc_beat[l];
      end
    end else if (state_q == StSqr) begin
      acc_d[1] = sq2;
      acc_d[3] = sq4;
      acc_d[5] = gf_sq(acc_q[2], code_q);
      acc_d[7] = gf_sq(sq4, code_q);
    end
  end

  // t=2 codes expose only S1..S4; the upper lanes read zero.
  always_comb begin
    syn_o = '0;
    for (int unsigned l = 0; l < NumLanes; l++) begin
      if ((l < T2Lanes) || (code_q == 2'd3)) syn_o[l*MMax +: MMax] = acc_q[l];
    end
  end

  assign syn_zero_o = syn_valid_o && (syn_o == '0);

endmodule

// File: tb/tb_bch_syndrome_gen.sv
// Bench for bch_syndrome_gen: directed and random words checked against a power-sum syndrome model.
module tb_bch_syndrome_gen;

`ifdef BCH_SYN_EVEN_SQR_EN
  localparam int ExpLat = 2;
`else
  localparam int ExpLat = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, start, in_valid, syn_ready;
  logic [1:0]  code;
  logic [7:0]  in_bits;
  logic        in_ready, syn_valid, syn_zero, busy;
  logic [79:0] syn;

  int          total = 0;
  int          bad = 0;
  bit          rx [1024];
  int          b7_mode = 2;
  logic [79:0] last_syn;

  always #5 clk = ~clk;

  bch_syndrome_gen dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .code_i     (code),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_bits_i  (in_bits),
    .syn_valid_o(syn_valid),
    .syn_ready_i(syn_ready),
    .syn_o      (syn),
    .syn_zero_o (syn_zero),
    .busy_o     (busy)
  );

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int field_n(input int c);
    return (c == 1) ? 63 : (c == 2) ? 255 : 1023;
  endfunction

  // S_j = sum over set r_i of alpha^(i*j mod n), with alpha powers from the primitive polynomial.
  function automatic logic [79:0] ref_syn(input int c);
    int m, n, poly, nl, a, s;
    int pw [1024];
    logic [79:0] r;
    m    = (c == 1) ? 6 : (c == 2) ? 8 : 10;
    poly = (c == 1) ? 'h43 : (c == 2) ? 'h11d : 'h409;
    n    = field_n(c);
    nl   = (c == 3) ? 8 : 4;
    pw[0] = 1;
    for (int e = 1; e < n; e++) begin
      a = pw[e-1] << 1;
      if (((a >> m) & 1) != 0) a = a ^ poly;
      pw[e] = a;
    end
    r = '0;
    for (int j = 1; j <= nl; j++) begin
      s = 0;
      for (int i = 0; i < n; i++) if (rx[i]) s = s ^ pw[(i * j) % n];
      r[10*(j-1) +: 10] = s[9:0];
    end
    return r;
  endfunction

  function automatic logic [7:0] get_beat(input int k, input int n);
    logic [7:0] v;
    int p;
    for (int b = 7; b >= 0; b--) begin
      if (k == 0 && b == 7) begin
        v[b] = (b7_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(b7_mode);
      end else begin
        p    = (k == 0) ? (6 - b) : (7 + 8 * (k - 1) + (7 - b));
        v[b] = rx[n - 1 - p];
      end
    end
    return v;
  endfunction

  task automatic make_word(input int c, input int kind);
    int n, k;
    n = field_n(c);
    for (int i = 0; i < 1024; i++) rx[i] = 1'b0;
    if (kind == 1) begin
      k = $urandom_range(1, 4);
      repeat (k) rx[$urandom_range(0, n - 1)] = 1'b1;
    end else if (kind == 2) begin
      for (int i = 0; i < n; i++) rx[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_word(input int c, input int gap_pct, input int hold, input string tag);
    logic [79:0] exp;
    int nb, n, lat, gaps;
    exp = ref_syn(c);
    n   = field_n(c);
    nb  = (n + 1) / 8;
    @(negedge clk);
    start = 1'b1;
    code  = 2'(c);
    @(negedge clk);
    start = 1'b0;
    code  = 2'd0;
    chk({tag, "_busy"}, busy, 1);
    for (int k = 0; k < nb; k++) begin
      gaps = 0;
      while (gaps < 4 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b1;
          code  = 2'd1;
        end
        @(negedge clk);
        start = 1'b0;
        code  = 2'd0;
        gaps++;
      end
      in_valid = 1'b1;
      in_bits  = get_beat(k, n);
      if (k == 0 || k == nb - 1) chk({tag, "_in_ready"}, in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_bits  = 8'h00;
    lat = 1;
    while (!syn_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, ExpLat);
    last_syn = syn;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk({tag, "_syn"}, syn, exp);
      chk({tag, "_zero"}, syn_zero, (exp == '0));
      chk({tag, "_valid"}, syn_valid, 1);
    end
    syn_ready = 1'b1;
    @(negedge clk);
    syn_ready = 1'b0;
    chk({tag, "_valid_fall"}, syn_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; code = 2'd0; in_valid = 1'b0; in_bits = 8'h00; syn_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_syn", syn, 0);
    chk("reset_flags", {in_ready, syn_valid, syn_zero, busy}, 0);

    in_valid = 1'b1;
    in_bits  = 8'hff;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
    in_valid = 1'b0;

    make_word(1, 0);
    run_word(1, 0, 0, "t1_zero");

    make_word(1, 0);
    rx[1] = 1'b1;
    run_word(1, 0, 0, "t2_r1");
    chk("t2_const", last_syn, {40'd0, 10'd16, 10'd8, 10'd4, 10'd2});

    make_word(1, 0);
    rx[62]  = 1'b1;
    b7_mode = 0;
    run_word(1, 0, 0, "t3_b7lo");
    chk("t3_s1", last_syn[9:0], 33);
    chk("t3_s2", last_syn[19:10], 49);
    b7_mode = 1;
    run_word(1, 0, 0, "t3_b7hi");
    chk("t3_b7hi_s1", last_syn[9:0], 33);
    chk("t3_b7hi_s2", last_syn[19:10], 49);
    b7_mode = 2;

    make_word(3, 0);
    rx[1] = 1'b1;
    rx[0] = 1'b1;
    run_word(3, 0, 0, "t4_c3");
    chk("t4_const", last_syn,
        {10'd257, 10'd129, 10'd65, 10'd33, 10'd17, 10'd9, 10'd5, 10'd3});

    make_word(2, 2);
    run_word(2, 40, 5, "t5_hold_gaps");

    for (int it = 0; it < 6; it++) begin
      make_word(it % 3 + 1, int'($urandom_range(1, 2)));
      run_word(it % 3 + 1, int'($urandom_range(0, 50)), int'($urandom_range(0, 2)), "rand");
    end

    // Reset partway through a code=2 word.
    make_word(2, 2);
    @(negedge clk);
    start = 1'b1;
    code  = 2'd2;
    @(negedge clk);
    start = 1'b0;
    code  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_bits  = get_beat(k, 255);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_syn", syn, 0);
    chk("t6_rst_flags", {in_ready, syn_valid, syn_zero, busy}, 0);
    rst = 1'b0;

    make_word(2, 0);
    run_word(2, 0, 0, "t6_zero");

    @(negedge clk);
    start = 1'b1;
    code  = 2'd0;
    @(negedge clk);
    start = 1'b0;
    chk("t6_code0_busy", busy, 0);
    chk("t6_code0_ready", in_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
